rom_loader: RTL and testbench
=============================

# rom_loader

Buffered boot-image loader between the SPI ioctl download port and the SDRAM write path. It translates the firmware byte stream (index 0) into 23-bit SDRAM addresses and bank selects for the CPC 6128/664 ROM sets and the Multiface Two ROM. It buffers bytes in a 4-entry FIFO and issues writes to the SDRAM controller through a req/ack handshake. It holds the machine in reset until every accepted byte has been committed.

## Interface

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- WAIT_LVL, 3: FIFO occupancy at which ioctl_wait asserts.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- nreset  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download target; only 0 (ROM) is handled.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte offset within the image.
- ioctl_dout  in  8  byte value.
- ioctl_wait  out  1  back-pressure to the ioctl source.
- mem_req  out  1  SDRAM write request.
- mem_ack  in  1  SDRAM accepted the presented word this cycle.
- mem_a  out  23  SDRAM byte address.
- mem_bank  out  2  SDRAM bank.
- mem_din  out  8  write data.
- busy  out  1  loader active; ORed into the machine reset.
- done  out  1  one-cycle pulse when a load is fully committed.
- overflow  out  1  sticky: at least one byte was dropped because the FIFO was full.
- skipped  out  1  sticky: at least one byte fell outside the mapped segments.
- byte_cnt  out  25  bytes committed to SDRAM in the current load.

## Operation

- Active stream: rom_dl = ioctl_download & (ioctl_index == 0). Strobes are ignored when rom_dl is low.
- Segment mapping uses seg = ioctl_addr[24:14] and passes mem_a[13:0] = ioctl_addr[13:0] through unchanged.
  - seg 0 or 4: mem_a[22:14] = 9'h000.
  - seg 1 or 5: 9'h100.
  - seg 2 or 6: 9'h107.
  - seg 3 or 7: 9'h1ff (MF2 ROM).
  - seg 4–7: mem_bank = 1. seg 0–3: mem_bank = 0.
  - seg > 7: byte is not enqueued and skipped is set.
- FIFO entry = {bank[1:0], a[22:0], data[7:0]}. Mapping is computed before the push.
- State machine IDLE / LOAD / DRAIN / DONE:
  - IDLE → LOAD on rising edge of rom_dl. On entry, clear byte_cnt, overflow and skipped. FIFO contents are kept.
  - LOAD → DRAIN when rom_dl falls.
  - DRAIN → DONE when the FIFO is empty and no request is pending.
  - DRAIN → LOAD if rom_dl rises again. byte_cnt and the sticky flags are not cleared on this path.
  - DONE → IDLE unconditionally after 1 cycle. done = 1 only in DONE.
- busy = 1 in LOAD and DRAIN, and also in the cycle rom_dl first rises.
- The FIFO is written in LOAD only. Popping continues in LOAD and DRAIN.
- byte_cnt increments on every acknowledged write and saturates at 2^25−1.

## Timing

- Push: a qualifying ioctl_wr sampled at edge N makes the entry visible at the head by edge N+1. mem_req can go high in cycle N+1 at the earliest.
- mem_req is high exactly when the FIFO is non-empty and the state is LOAD or DRAIN.
  - mem_a, mem_bank and mem_din show the head entry and stay stable while mem_req is high and mem_ack is low.
- Pop: mem_ack high with mem_req high at edge M pops the head.
  - The next entry, if any, is presented from M+1.
  - mem_ack while mem_req is low is ignored.
- Simultaneous push and pop in the same cycle is legal. Occupancy is unchanged.
- Full FIFO with a push and no pop: the byte is dropped, overflow is set, and occupancy stays at DEPTH.
- Full FIFO with a push and a pop in the same cycle: the push is accepted and nothing is dropped.
- ioctl_wait is registered, = (occupancy ≥ WAIT_LVL), one cycle of latency.
- Reset values while nreset is low: state IDLE, FIFO empty, and every output 0 (ioctl_wait, mem_req, mem_a, mem_bank, mem_din, busy, done, overflow, skipped, byte_cnt).
- Reset mid-load discards all buffered bytes. After release, the block restarts in IDLE and waits for a fresh rom_dl rising edge, even if rom_dl is already high.

## Test plan

- Write 4 bytes at addr 0x00000–0x00003 (0xAA..0xAD), mem_ack tied high → writes to mem_a 0x000000–0x000003, bank 0. byte_cnt = 4, one done pulse 1 cycle after drain completes.
- Write at addr 0x04000 and 0x1C123 (seg 1, seg 7) → mem_a 0x400000 bank 0 and 0x7FC123 bank 1. Write at seg 8 (0x20000) → no mem_req, skipped = 1.
- Hold mem_ack low, send 5 strobes → ioctl_wait high after occupancy reaches 3, 5th byte dropped, overflow = 1. Release ack → exactly 4 writes, byte_cnt = 4.
- Push every cycle while acking every cycle → no drops, mem_req continuous, mem_a increments by 1 each cycle.
- Assert nreset low with 3 bytes buffered → all outputs 0 immediately. After release with rom_dl still high → no writes, busy = 0.
- Strobes with ioctl_index = 1 → no writes, busy stays 0.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: buffers the ioctl ROM download stream, maps image offsets onto
// the CPC / MF2 SDRAM layout and commits bytes through a req/ack write port.
module rom_loader #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WAIT_LVL = 3
) (
    input  logic        clk_sys,
    input  logic        nreset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [22:0] mem_a,
    output logic [1:0]  mem_bank,
    output logic [7:0]  mem_din,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        skipped,
    output logic [24:0] byte_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = 2 + 23 + 8;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_t;

    state_t          state_q;
    logic            rom_dl;
    logic            rom_dl_q;
    logic            rom_rise;
    logic [10:0]     seg;
    logic            seg_ok;
    logic [8:0]      map_hi;
    logic [EW-1:0]   entry;
    logic [EW-1:0]   head;
    logic [EW-1:0]   fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            full;
    logic            strobe;
    logic            push;
    logic            pop;
    logic            drop;
    logic            wait_q;

    assign rom_dl   = ioctl_download & (ioctl_index == 8'd0);
    assign rom_rise = rom_dl & ~rom_dl_q;

    assign seg    = ioctl_addr[24:14];
    assign seg_ok = (seg < 11'd8);

    // Upper SDRAM address bits for each 16 KiB image segment
    always_comb begin
        map_hi = 9'h000;
        unique case (seg[1:0])
            2'd0: map_hi = 9'h000;
            2'd1: map_hi = 9'h100;
            2'd2: map_hi = 9'h107;
            2'd3: map_hi = 9'h1ff;
            default: map_hi = 9'h000;
        endcase
    end

    assign entry = {1'b0, seg[2], map_hi, ioctl_addr[13:0], ioctl_dout};
    assign head  = fifo_mem[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));

    assign mem_req = (count_q != '0) & ((state_q == StLoad) | (state_q == StDrain));
    assign pop     = mem_req & mem_ack;
    assign strobe  = (state_q == StLoad) & rom_dl & ioctl_wr;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    assign push    = strobe & seg_ok & (~full | pop);
    assign drop    = strobe & seg_ok & full & ~pop;

    // Outputs are forced low when no request is presented
    assign mem_bank = mem_req ? head[32:31] : 2'b00;
    assign mem_a    = mem_req ? head[30:8]  : 23'd0;
    assign mem_din  = mem_req ? head[7:0]   : 8'd0;

    assign busy       = (state_q == StLoad) | (state_q == StDrain) |
                        ((state_q == StIdle) & rom_rise);
    assign done       = (state_q == StDone);
    assign ioctl_wait = wait_q;

    // Edge history for rom_dl; resets high so a stream already active at
    // reset release is not mistaken for a new download
    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            rom_dl_q <= 1'b1;
        end else begin
            rom_dl_q <= rom_dl;
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= entry;
                wr_ptr_q           <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Registered back-pressure from current occupancy
    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            wait_q <= 1'b0;
        end else begin
            wait_q <= (count_q >= CW'(WAIT_LVL));
        end
    end

    // Load sequencing, committed-byte counter and sticky status flags
    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            state_q  <= StIdle;
            byte_cnt <= '0;
            overflow <= 1'b0;
            skipped  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rom_rise) begin
                        state_q  <= StLoad;
                        byte_cnt <= '0;
                        overflow <= 1'b0;
                        skipped  <= 1'b0;
                    end
                end
                StLoad: begin
                    if (!rom_dl) state_q <= StDrain;
                end
                StDrain: begin
                    if (rom_rise) begin
                        state_q <= StLoad;
                    end else if (count_q == '0) begin
                        state_q <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            // Pops and strobes only happen in LOAD/DRAIN, never with the IDLE clear
            if (pop && (byte_cnt != '1)) byte_cnt <= byte_cnt + 25'd1;
            if (drop) overflow <= 1'b1;
            if (strobe && !seg_ok) skipped <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: stimulus pushes expected SDRAM writes,
// an independent monitor pops and compares on every acknowledged request.
module tb_rom_loader;

    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        nreset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        mem_req;
    logic        mem_ack;
    logic [22:0] mem_a;
    logic [1:0]  mem_bank;
    logic [7:0]  mem_din;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        skipped;
    logic [24:0] byte_cnt;

    int total = 0;
    int bad   = 0;
    int writes = 0;
    logic [32:0] exp_q[$];

    rom_loader #(.DEPTH(DEPTH), .WAIT_LVL(3)) dut (
        .clk_sys(clk_sys), .nreset(nreset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_a(mem_a), .mem_bank(mem_bank), .mem_din(mem_din),
        .busy(busy), .done(done), .overflow(overflow), .skipped(skipped),
        .byte_cnt(byte_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference mapping: 16 KiB segments 0..7, bases repeat every four segments
    function automatic bit map_addr(input logic [24:0] addr, output logic [22:0] a,
                                    output logic [1:0] bank);
        int seg;
        int base;
        seg  = int'(addr / 25'd16384);
        a    = '0;
        bank = '0;
        if (seg > 7) return 1'b0;
        case (seg % 4)
            0: base = 'h000;
            1: base = 'h100;
            2: base = 'h107;
            default: base = 'h1ff;
        endcase
        a    = 23'(base * 16384 + int'(addr % 25'd16384));
        bank = 2'(seg / 4);
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [24:0] addr, input logic [7:0] d, input bit accept);
        logic [22:0] a;
        logic [1:0]  b;
        ioctl_addr = addr;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (map_addr(addr, a, b) && accept) exp_q.push_back({b, a, d});
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        check("busy_on_rise", busy, (idx == 8'd0));
        tick();
        if (idx == 8'd0) begin
            check("cnt_clr", byte_cnt, 0);
            check("ovf_clr", overflow, 0);
            check("skip_clr", skipped, 0);
        end
    endtask

    task automatic end_dl(input int exp_cnt, input bit exp_ovf, input bit exp_skip);
        bit found = 1'b0;
        ioctl_download = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk_sys);
            if (done) found = 1'b1;
        end
        check("done_seen", found, 1);
        if (found) begin
            check("byte_cnt", byte_cnt, exp_cnt);
            check("overflow", overflow, exp_ovf);
            check("skipped", skipped, exp_skip);
            check("busy_done", busy, 0);
            check("sb_empty", exp_q.size(), 0);
            @(negedge clk_sys);
            check("done_pulse", done, 0);
        end
        tick();
    endtask

    task automatic check_all_zero();
        check("rst_wait", ioctl_wait, 0);
        check("rst_req", mem_req, 0);
        check("rst_a", mem_a, 0);
        check("rst_bank", mem_bank, 0);
        check("rst_din", mem_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_skip", skipped, 0);
        check("rst_cnt", byte_cnt, 0);
    endtask

    // Monitor: compare each accepted write with the scoreboard head and
    // require stable outputs while a request is stalled
    initial begin
        logic        hold_v;
        logic [32:0] hold_e;
        logic [32:0] e;
        hold_v = 1'b0;
        hold_e = '0;
        forever begin
            @(negedge clk_sys);
            if (nreset) begin
                if (hold_v && mem_req) check("hold_stable", {mem_bank, mem_a, mem_din}, hold_e);
                if (mem_req && mem_ack) begin
                    writes++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got %0h expected none",
                                 {mem_bank, mem_a, mem_din});
                    end else begin
                        e = exp_q.pop_front();
                        check("write", {mem_bank, mem_a, mem_din}, e);
                    end
                end
                hold_v = mem_req && !mem_ack;
                hold_e = {mem_bank, mem_a, mem_din};
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        int cnt;
        bit skp;
        int seg;
        logic [22:0] ta;
        logic [1:0]  tb_bank;
        logic [24:0] addr;

        nreset = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        mem_ack = 1'b0;
        tick();
        tick();
        check_all_zero();
        nreset = 1'b1;
        tick();

        // Four sequential bytes, ack tied high
        mem_ack = 1'b1;
        start_dl(8'd0);
        for (int i = 0; i < 4; i++) strobe(25'(i), 8'(8'hAA + i), 1'b1);
        end_dl(4, 1'b0, 1'b0);

        // Segment mapping and out-of-range skip
        start_dl(8'd0);
        strobe(25'h04000, 8'h11, 1'b1);
        strobe(25'h1C123, 8'h22, 1'b1);
        strobe(25'h20000, 8'h33, 1'b1);
        end_dl(2, 1'b0, 1'b1);

        // Overflow with ack held low
        mem_ack = 1'b0;
        start_dl(8'd0);
        for (int i = 0; i < 5; i++) strobe(25'(16 + i), 8'(8'h50 + i), (i < DEPTH));
        tick();
        check("wait_full", ioctl_wait, 1);
        check("ovf_set", overflow, 1);
        check("req_full", mem_req, 1);
        mem_ack = 1'b1;
        end_dl(4, 1'b1, 1'b0);

        // Back-to-back push and pop
        start_dl(8'd0);
        for (int i = 0; i < 16; i++) begin
            strobe(25'(25'h08000 + i), 8'(i * 7), 1'b1);
            @(negedge clk_sys);
            check("req_cont", mem_req, 1);
        end
        check("wait_stream", ioctl_wait, 0);
        end_dl(16, 1'b0, 1'b0);

        // Randomised loads with random ack; never exceed FIFO capacity
        for (int l = 0; l < 4; l++) begin
            cnt = 0;
            skp = 1'b0;
            start_dl(8'd0);
            for (int c = 0; c < 60; c++) begin
                mem_ack = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 1) == 1 && exp_q.size() < DEPTH) begin
                    seg  = $urandom_range(0, 9);
                    addr = 25'(seg * 16384 + $urandom_range(0, 16383));
                    if (map_addr(addr, ta, tb_bank)) cnt++;
                    else skp = 1'b1;
                    strobe(addr, 8'($urandom_range(0, 255)), 1'b1);
                end else begin
                    tick();
                end
            end
            mem_ack = 1'b1;
            end_dl(cnt, 1'b0, skp);
        end

        // Reset mid-load with three buffered bytes
        mem_ack = 1'b0;
        start_dl(8'd0);
        for (int i = 0; i < 3; i++) strobe(25'(i), 8'(i + 1), 1'b1);
        tick();
        tick();
        check("wait_three", ioctl_wait, 1);
        nreset = 1'b0;
        #1;
        check_all_zero();
        exp_q.delete();
        tick();
        nreset = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            check("post_rst_busy", busy, 0);
            check("post_rst_req", mem_req, 0);
        end
        ioctl_download = 1'b0;
        tick();

        // Non-ROM index is ignored entirely
        start_dl(8'd1);
        for (int i = 0; i < 4; i++) begin
            strobe(25'(i), 8'hEE, 1'b0);
            @(negedge clk_sys);
            check("idx1_busy", busy, 0);
        end
        ioctl_download = 1'b0;
        tick();
        tick();
        check("idx1_done", done, 0);
        check("sb_final", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
